// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// bsg_cache_to_dram_ctrl_rx
//
// Read-return path from the DRAM controller's native read-data port to the
// cache DMA data inputs. Each accepted read-request tag names the cache that
// will receive the next block of block_size_in_words_p words. The controller
// pushes read beats with no backpressure. The beats are buffered in a data
// FIFO and steered, one word per cycle, to the cache named by the head tag.
// A credit counter reserves buffer space per block at tag-accept time, so
// data that was legally requested can never overflow the buffer.
//
// Handshakes (valid/ready): a transfer happens in a cycle where both valid
// and ready are 1 at the rising clock edge. Valid never depends
// combinationally on ready. Tag side: v_i/ready_o. Cache side:
// dma_data_v_o[i]/dma_data_ready_i[i]. The controller side
// (app_rd_data_valid_i) has no ready. Every beat is taken or, if the buffer
// is full, dropped and flagged.
//
// Ports
//   clk_i, reset_n_i     : clock, asynchronous active-low reset
//   v_i, tag_i, ready_o  : read-request tag input (cache index)
//   app_rd_data_valid_i  : controller read beat valid
//   app_rd_data_i        : controller read beat data
//   app_rd_data_end_i    : last beat of a controller burst
//   dma_data_o           : head word of the data FIFO, shared by all caches
//   dma_data_v_o         : one-hot valid to the cache named by the head tag
//   dma_data_ready_i     : per-cache ready
//   error_o              : sticky protocol error (overrun / unreserved beat /
//                          burst-end mismatch)
module bsg_cache_to_dram_ctrl_rx #(
  parameter int num_cache_p           = 1,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int dram_ctrl_burst_len_p = 1,
  parameter int tag_fifo_els_p        = 4,
  parameter int data_fifo_els_p       = 8,
  localparam int tag_width_lp = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic                    v_i,
  input  logic [tag_width_lp-1:0] tag_i,
  output logic                    ready_o,

  input  logic                    app_rd_data_valid_i,
  input  logic [data_width_p-1:0] app_rd_data_i,
  input  logic                    app_rd_data_end_i,

  output logic [data_width_p-1:0] dma_data_o,
  output logic [num_cache_p-1:0]  dma_data_v_o,
  input  logic [num_cache_p-1:0]  dma_data_ready_i,

  output logic                    error_o
);

  localparam int credit_w_lp = $clog2(data_fifo_els_p + 1);
  localparam int daddr_w_lp  = (data_fifo_els_p > 1) ? $clog2(data_fifo_els_p) : 1;
  localparam int taddr_w_lp  = (tag_fifo_els_p > 1) ? $clog2(tag_fifo_els_p) : 1;
  localparam int tcnt_w_lp   = $clog2(tag_fifo_els_p + 1);
  localparam int word_w_lp   = $clog2(block_size_in_words_p);
  localparam int beat_w_lp   = (dram_ctrl_burst_len_p > 1) ? $clog2(dram_ctrl_burst_len_p) : 1;

  localparam logic [credit_w_lp-1:0] credit_full_lp  = credit_w_lp'(data_fifo_els_p);
  localparam logic [credit_w_lp-1:0] block_credit_lp = credit_w_lp'(block_size_in_words_p);
  localparam logic [daddr_w_lp-1:0]  daddr_last_lp   = daddr_w_lp'(data_fifo_els_p - 1);
  localparam logic [taddr_w_lp-1:0]  taddr_last_lp   = taddr_w_lp'(tag_fifo_els_p - 1);
  localparam logic [tcnt_w_lp-1:0]   tcnt_full_lp    = tcnt_w_lp'(tag_fifo_els_p);
  localparam logic [word_w_lp-1:0]   word_last_lp    = word_w_lp'(block_size_in_words_p - 1);
  localparam logic [beat_w_lp-1:0]   beat_last_lp    = beat_w_lp'(dram_ctrl_burst_len_p - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [data_width_p-1:0] dmem [data_fifo_els_p];
  logic [tag_width_lp-1:0] tmem [tag_fifo_els_p];

  logic [daddr_w_lp-1:0]  d_wptr_r, d_rptr_r, d_wptr_n, d_rptr_n;
  logic [credit_w_lp-1:0] d_cnt_r, d_cnt_n;
  logic [taddr_w_lp-1:0]  t_wptr_r, t_rptr_r, t_wptr_n, t_rptr_n;
  logic [tcnt_w_lp-1:0]   t_cnt_r, t_cnt_n;
  // credits_r: buffer words not yet promised to any outstanding block.
  // pend_r: words reserved by accepted tags that have not arrived yet.
  logic [credit_w_lp-1:0] credits_r, credits_n;
  logic [credit_w_lp-1:0] pend_r, pend_n;
  logic [word_w_lp-1:0]   word_r, word_n;
  logic [beat_w_lp-1:0]   beat_r, beat_n;
  logic                   error_r, error_n;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic                    d_full, d_v, d_enq;
  logic                    t_full, t_v, t_enq, t_deq;
  logic                    xfer, last_word;
  logic [tag_width_lp-1:0] head_tag;
  logic                    err_drop, err_unres, err_end;

  assign d_full   = (d_cnt_r == credit_full_lp);
  assign d_v      = (d_cnt_r != '0);
  assign t_full   = (t_cnt_r == tcnt_full_lp);
  assign t_v      = (t_cnt_r != '0);
  assign head_tag = tmem[t_rptr_r];

  assign ready_o  = ~t_full & (credits_r >= block_credit_lp);
  assign t_enq    = v_i & ready_o;

  for (genvar i = 0; i < num_cache_p; i++) begin : g_dma_v
    assign dma_data_v_o[i] = d_v & t_v & (head_tag == tag_width_lp'(i));
  end

  assign dma_data_o = dmem[d_rptr_r];
  assign xfer       = |(dma_data_v_o & dma_data_ready_i);
  assign last_word  = (word_r == word_last_lp);
  assign t_deq      = xfer & last_word;

  // A beat arriving on a full buffer still fits if a word leaves this cycle.
  assign d_enq     = app_rd_data_valid_i & (~d_full | xfer);
  assign err_drop  = app_rd_data_valid_i & d_full & ~xfer;
  assign err_unres = app_rd_data_valid_i & (pend_r == '0);
  assign err_end   = app_rd_data_valid_i & (app_rd_data_end_i != (beat_r == beat_last_lp));

  assign error_o = error_r;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    d_wptr_n  = d_wptr_r;
    d_rptr_n  = d_rptr_r;
    t_wptr_n  = t_wptr_r;
    t_rptr_n  = t_rptr_r;
    word_n    = word_r;
    beat_n    = beat_r;

    if (d_enq) d_wptr_n = (d_wptr_r == daddr_last_lp) ? '0 : d_wptr_r + daddr_w_lp'(1);
    if (xfer)  d_rptr_n = (d_rptr_r == daddr_last_lp) ? '0 : d_rptr_r + daddr_w_lp'(1);
    if (t_enq) t_wptr_n = (t_wptr_r == taddr_last_lp) ? '0 : t_wptr_r + taddr_w_lp'(1);
    if (t_deq) t_rptr_n = (t_rptr_r == taddr_last_lp) ? '0 : t_rptr_r + taddr_w_lp'(1);

    d_cnt_n = d_cnt_r + credit_w_lp'(d_enq) - credit_w_lp'(xfer);
    t_cnt_n = t_cnt_r + tcnt_w_lp'(t_enq) - tcnt_w_lp'(t_deq);

    // Reservation and return may coincide; they apply as a net change.
    credits_n = credits_r - (t_enq ? block_credit_lp : '0) + credit_w_lp'(xfer);
    pend_n    = pend_r + (t_enq ? block_credit_lp : '0)
              - credit_w_lp'(app_rd_data_valid_i & (pend_r != '0));

    if (xfer) word_n = last_word ? '0 : word_r + word_w_lp'(1);
    if (app_rd_data_valid_i) beat_n = (beat_r == beat_last_lp) ? '0 : beat_r + beat_w_lp'(1);

    error_n = error_r | err_drop | err_unres | err_end;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      d_wptr_r  <= '0;
      d_rptr_r  <= '0;
      d_cnt_r   <= '0;
      t_wptr_r  <= '0;
      t_rptr_r  <= '0;
      t_cnt_r   <= '0;
      credits_r <= credit_full_lp;
      pend_r    <= '0;
      word_r    <= '0;
      beat_r    <= '0;
      error_r   <= 1'b0;
    end else begin
      d_wptr_r  <= d_wptr_n;
      d_rptr_r  <= d_rptr_n;
      d_cnt_r   <= d_cnt_n;
      t_wptr_r  <= t_wptr_n;
      t_rptr_r  <= t_rptr_n;
      t_cnt_r   <= t_cnt_n;
      credits_r <= credits_n;
      pend_r    <= pend_n;
      word_r    <= word_n;
      beat_r    <= beat_n;
      error_r   <= error_n;
    end
  end

  // Storage arrays are not reset. Their contents are only observed through a
  // valid head, and the counters guarantee no stale entry is ever valid.
  always_ff @(posedge clk_i) begin
    if (d_enq) dmem[d_wptr_r] <= app_rd_data_i;
    if (t_enq) tmem[t_wptr_r] <= tag_i;
  end

endmodule
